// File: rtl/divu_hilo_unit.sv
// Multicycle unsigned restoring divider (DIVU) that writes the remainder to HI and the quotient to LO.
// One shift-subtract step per clock. Results appear WIDTH cycles after the start edge.
module divu_hilo_unit #(
  parameter int         WIDTH     = 32,
  parameter logic [5:0] DIVU_CODE = 6'b011011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    count;

  logic             start;
  logic             last;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] next_quo;

  // The shifted remainder keeps the bit pushed out of rem, so the trial subtraction
  // stays exact even when the divisor uses the top bit; trial[WIDTH] is the borrow.
  always_comb begin
    start    = (Signal == DIVU_CODE);
    last     = (count == CW'(WIDTH - 1));
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    next_rem = shifted[WIDTH-1:0];
    next_quo = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      next_rem = trial[WIDTH-1:0];
      next_quo = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      count   <= '0;
      HiOut   <= '0;
      LoOut   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // The done cycle accepts a new start exactly like idle, allowing back-to-back issue.
        IDLE, DONE: begin
          if (start) begin
            quo     <= dataA;
            divisor <= dataB;
            rem     <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          rem   <= next_rem;
          quo   <= next_quo;
          count <= count + CW'(1);
          if (last) begin
            HiOut <= next_rem;
            LoOut <= next_quo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
